// File: rtl/token_pkt_tx_pkg.sv
// token_pkt_tx_pkg
// Shared definitions for the DVFS token packet transmitter: flit layout,
// preamble codes, message type, FIFO geometry and the transmit FSM states.
// No ports (package).

package token_pkt_tx_pkg;

  // Flit geometry: 2-bit preamble on top of a 32-bit body.
  localparam int unsigned FLIT_W     = 34;
  localparam int unsigned BODY_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned VAL_W      = 32;
  localparam int unsigned TILE_W     = 5;

  // Buffer between the divider stage and the NoC.
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_CNT_W = 3;
  localparam int unsigned ENTRY_W    = ADDR_W + VAL_W;

  localparam logic [1:0] PREAMBLE_HEAD = 2'b10;
  localparam logic [1:0] PREAMBLE_TAIL = 2'b01;
  localparam logic [5:0] TOKEN_MSG     = 6'h2A;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHead = 2'd1,
    StTail = 2'd2
  } tx_state_e;

  // One buffered token: destination plus payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  val;
  } token_entry_t;

  // Head flit: {preamble, 16'b0, msg type, source tile, destination}.
  function automatic logic [FLIT_W-1:0] make_head_flit(input logic [ADDR_W-1:0] addr,
                                                       input logic [TILE_W-1:0] src);
    return {PREAMBLE_HEAD, 16'h0000, TOKEN_MSG, src, addr};
  endfunction

  // Tail flit carries the payload verbatim, zero included.
  function automatic logic [FLIT_W-1:0] make_tail_flit(input logic [VAL_W-1:0] val);
    return {PREAMBLE_TAIL, val};
  endfunction

endpackage

// File: rtl/token_pkt_fifo.sv
// token_pkt_fifo
// Small synchronous FIFO holding {addr, val} token entries.
// Ports:
//   clock  in   rising-edge clock
//   rst    in   asynchronous active-high reset (clears pointers and count)
//   push   in   write wdata (ignored when full)
//   pop    in   drop the head entry (ignored when empty)
//   wdata  in   entry to store
//   rdata  out  head entry (valid when !empty)
//   full   out  count == Depth, decoded from the registered count
//   empty  out  count == 0
//   count  out  occupied entries

module token_pkt_fifo
  import token_pkt_tx_pkg::*;
#(
  parameter int unsigned Width = ENTRY_W,
  parameter int unsigned Depth = FIFO_DEPTH
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [Width-1:0]             wdata,
  output logic [Width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through rdata while non-empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/token_pkt_tx.sv
// token_pkt_tx
// Buffers DVFS token results from the divider stage and sends each one to
// the NoC as a two-flit packet (head, then tail).
// Ports:
//   clock            in   sole clock, rising edge
//   rst              in   asynchronous active-high reset
//   packet_out       in   divider result valid, held while pending
//   packet_out_addr  in   destination tile address
//   packet_out_val   in   token payload
//   local_tile_id    in   source tile id (quasi-static)
//   enable           in   gate for starting new packets
//   noc_ready        in   NoC accepts the current flit
//   noc_valid        out  flit valid
//   noc_flit         out  [33:32] preamble, [31:0] body
//   freeze           out  hold request to the divider stage (FIFO full)
//   fifo_count       out  buffered entries, 0..4
//   pkt_sent_count   out  completed packets, wrapping
//   idle             out  nothing buffered, nothing in flight

module token_pkt_tx
  import token_pkt_tx_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  packet_out,
  input  logic [ADDR_W-1:0]     packet_out_addr,
  input  logic [VAL_W-1:0]      packet_out_val,
  input  logic [TILE_W-1:0]     local_tile_id,
  input  logic                  enable,
  input  logic                  noc_ready,
  output logic                  noc_valid,
  output logic [FLIT_W-1:0]     noc_flit,
  output logic                  freeze,
  output logic [FIFO_CNT_W-1:0] fifo_count,
  output logic [15:0]           pkt_sent_count,
  output logic                  idle
);

  tx_state_e          state_q, state_d;
  token_entry_t       wr_entry, rd_entry;
  logic [ENTRY_W-1:0] rd_bits;
  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [15:0]        sent_q, sent_d;

  assign wr_entry  = '{addr: packet_out_addr, val: packet_out_val};
  assign rd_entry  = rd_bits;

  // fifo_full is decoded from the registered count, so freeze has no
  // combinational path from packet_out.
  assign freeze    = fifo_full;
  assign fifo_push = packet_out && !freeze;

  token_pkt_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_entry),
    .rdata (rd_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and flit outputs. The head entry stays in the FIFO until the
  // tail handshake, so the flit is stable for the whole of a stall.
  always_comb begin
    state_d   = state_q;
    noc_valid = 1'b0;
    noc_flit  = '0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && enable) begin
          state_d = StHead;
        end
      end
      StHead: begin
        noc_valid = 1'b1;
        noc_flit  = make_head_flit(rd_entry.addr, local_tile_id);
        if (noc_ready) begin
          state_d = StTail;
        end
      end
      StTail: begin
        noc_valid = 1'b1;
        noc_flit  = make_tail_flit(rd_entry.val);
        if (noc_ready) begin
          fifo_pop = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A packet counts as sent on the tail handshake, which is also the pop.
  assign sent_d = fifo_pop ? sent_q + 16'd1 : sent_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
    end
  end

  assign pkt_sent_count = sent_q;
  assign idle           = fifo_empty && (state_q == StIdle) && !noc_valid;

endmodule
